muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative RV64M multiply/divide unit with sequencing FSM; serves MUL*/DIV*/REM* and word forms.
//  Sits beside the single-cycle ALU in EX. Core stalls on busy until the result is consumed.
//  Radix-2 shift-add multiply, restoring divide, one bit per cycle; RISC-V special cases fast-pathed.
// PARAMETERS
//  XLEN   64                  operand/result width
//  CNT_W  $clog2(XLEN)+1      iteration counter width
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  req_valid    in   1     request present
//  req_ready    out  1     request accepted when req_valid && req_ready
//  req_funct3   in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  req_word     in   1     1 = *W form (OP_RTYPE_W): 32-bit operate, sign-extend result
//  req_rs1      in   XLEN  operand A (dividend / multiplicand)
//  req_rs2      in   XLEN  operand B (divisor / multiplier)
//  flush        in   1     kill in-flight op, no response
//  resp_valid   out  1     result valid, held until resp_ready
//  resp_ready   in   1     consumer accepts result
//  resp_result  out  XLEN  result, stable while resp_valid
//  busy         out  1     op in flight or response pending (pipeline stall)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, all regs 0; resp_valid=0, resp_result=0, busy=0.
//  req_ready = (state==IDLE) && !flush; reads 1 out of reset. busy = (state!=IDLE).
//  FSM: IDLE -> PREP on accept (edge T). PREP(T+1): latch |A|,|B|, sign flags, N = req_word?32:XLEN.
//   PREP -> DONE if special, else -> BUSY. BUSY: N iterations, counter N-1..0. Last iter -> FIX.
//   FIX: sign correction, word truncation/sign-extension; -> DONE. DONE: resp_valid=1.
//   DONE -> IDLE on resp_ready. New request is not accepted in the same cycle.
//  Latency (accept at T): normal resp_valid first high in cycle T+N+3 (64b: T+67, W: T+35);
//   special cases resp_valid at T+2.
//  Specials (divide only, operands after word truncation):
//   B==0: DIV/DIVU -> all ones; REM/REMU -> A (word: sign-extended A[31:0]).
//   signed A==MIN, B==-1: DIV -> MIN; REM -> 0 (MIN = 1<<(N-1), sign-extended for W).
//  Signedness: MUL/MULH/DIV/REM signed both; MULHSU A signed, B unsigned; MULHU/DIVU/REMU unsigned.
//  Multiply: 2N-bit product of magnitudes, negate if signs differ. MUL -> low N; MULH* -> high N.
//  Divide: quotient sign = sA^sB; remainder sign = sA. *W result = sext(res[31:0]).
//  req_word with funct3 001-011 is treated as MULW.
//  Operands are captured at accept; input changes afterwards are ignored.
//  flush: any state -> IDLE next edge, resp_valid drops, no response emitted.
//   flush dominates resp_ready in DONE. flush in IDLE blocks accept that cycle.
//  Reset mid-operation: immediate abort to IDLE, no response.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined: multiply leaves BUSY for FIX once remaining multiplier bits are 0.
//   Checked after each iteration. Multiplier==0 at PREP goes straight to FIX (resp T+3).
//   Divide timing is unchanged.
//  Undefined: multiply always runs N iterations; latency fixed as above.
// TESTING
//  1 DIV A=0xFFFF_FFFF_FFFF_FFF9(-7) B=2 -> resp 0xFFFF_FFFF_FFFF_FFFD at T+67; REM same -> 0xFFFF_FFFF_FFFF_FFFF.
//  2 DIVU A=5 B=0 -> 0xFFFF_FFFF_FFFF_FFFF at T+2; REMU A=5 B=0 -> 5 at T+2.
//  3 DIV A=0x8000_0000_0000_0000 B=-1 -> 0x8000_0000_0000_0000 at T+2; REM -> 0;
//    DIVW A=0x8000_0000 B=-1 -> 0xFFFF_FFFF_8000_0000.
//  4 MULHU A=B=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE at T+67;
//    MULW A=0x7FFF_FFFF B=2 -> 0xFFFF_FFFF_FFFF_FFFE at T+35.
//  5 MUL 3*4 with resp_ready low 5 cycles in DONE -> resp_valid/result=12 stable, req_ready=0, busy=1.
//    Then flush at BUSY cycle 10 of a new DIV -> no resp_valid, req_ready=1 next cycle.
//  6 rst_n low mid-BUSY -> outputs 0 immediately; next op completes correctly.
//    With MULDIV_EARLY_OUT_EN: MUL A=9 B=1 -> 9 at T+4.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV64M multiply/divide unit sitting beside the EX ALU.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with the
// RISC-V divide-by-zero and signed-overflow cases resolved without iterating.
// Optional feature: define MULDIV_EARLY_OUT_EN to let a multiply stop iterating
// as soon as the remaining multiplier bits are all zero.
module muldiv_sequencer #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  localparam int WLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_accept;

  // Captured request
  logic [2:0]          r_funct3;
  logic                r_word;
  logic [XLEN-1:0]     r_opa;
  logic [XLEN-1:0]     r_opb;

  // Iteration datapath
  logic [2*XLEN-1:0]   r_mcand;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_mplier;
  logic [XLEN-1:0]     r_dsor;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_rem;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_neg;
  logic [XLEN-1:0]     r_result;

  // Operand decode (valid while in PREP)
  logic                w_is_div;
  logic                w_is_rem;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_sa;
  logic                w_sb;
  logic                w_b_zero;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_a_sext32;
  logic [XLEN-1:0]     w_b_sext32;
  logic [XLEN-1:0]     w_a_trunc;
  logic [XLEN-1:0]     w_b_trunc;
  logic [XLEN-1:0]     w_amag;
  logic [XLEN-1:0]     w_bmag;
  logic [XLEN-1:0]     w_min;
  logic [XLEN-1:0]     w_special_res;

  // Per-iteration and fix-up values
  logic [2*XLEN-1:0]   w_acc_next;
  logic [XLEN:0]       w_rem_sh;
  logic [XLEN:0]       w_diff;
  logic                w_qbit;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo_s;
  logic [XLEN-1:0]     w_rem_s;
  logic [XLEN-1:0]     w_raw;
  logic [XLEN-1:0]     w_fix_res;

  // Signedness follows funct3; word forms see only the low 32 bits, extended.
  assign w_is_div   = r_funct3[2];
  assign w_is_rem   = r_funct3[2] & r_funct3[1];
  assign w_a_signed = (r_funct3 != 3'b011) && (r_funct3 != 3'b101) && (r_funct3 != 3'b111);
  assign w_b_signed = (r_funct3 == 3'b000) || (r_funct3 == 3'b001) ||
                      (r_funct3 == 3'b100) || (r_funct3 == 3'b110);
  assign w_a_sext32 = {{(XLEN-WLEN){r_opa[WLEN-1]}}, r_opa[WLEN-1:0]};
  assign w_b_sext32 = {{(XLEN-WLEN){r_opb[WLEN-1]}}, r_opb[WLEN-1:0]};
  assign w_a_trunc  = !r_word    ? r_opa :
                      w_a_signed ? w_a_sext32 : {{(XLEN-WLEN){1'b0}}, r_opa[WLEN-1:0]};
  assign w_b_trunc  = !r_word    ? r_opb :
                      w_b_signed ? w_b_sext32 : {{(XLEN-WLEN){1'b0}}, r_opb[WLEN-1:0]};
  assign w_sa       = w_a_signed & w_a_trunc[XLEN-1];
  assign w_sb       = w_b_signed & w_b_trunc[XLEN-1];
  assign w_amag     = w_sa ? -w_a_trunc : w_a_trunc;
  assign w_bmag     = w_sb ? -w_b_trunc : w_b_trunc;
  assign w_min      = r_word ? {{(XLEN-WLEN+1){1'b1}}, {(WLEN-1){1'b0}}}
                             : {1'b1, {(XLEN-1){1'b0}}};
  assign w_b_zero   = (w_b_trunc == '0);
  assign w_ovf      = w_is_div & !r_funct3[0] & (w_a_trunc == w_min) & (w_b_trunc == '1);
  assign w_special  = w_is_div & (w_b_zero | w_ovf);

  // Fast-path result for divide-by-zero and signed MIN / -1
  always_comb begin
    w_special_res = '0;
    if (w_b_zero) begin
      w_special_res = w_is_rem ? (r_word ? w_a_sext32 : r_opa) : '1;
    end else if (!w_is_rem) begin
      w_special_res = w_a_trunc;
    end
  end

  // One multiply step (add shifted multiplicand) and one restoring divide step
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_dsor};
  assign w_qbit     = !w_diff[XLEN];

  // Sign correction and result selection for the FIX state
  assign w_prod  = r_neg ? -r_acc : r_acc;
  assign w_quo_s = r_neg ? -r_quo : r_quo;
  assign w_rem_s = r_neg ? -r_rem : r_rem;

  always_comb begin
    w_raw = '0;
    case (r_funct3)
      3'b000:                 w_raw = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_raw = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_raw = w_quo_s;
      default:                w_raw = w_rem_s;
    endcase
  end

  assign w_fix_res = r_word ? {{(XLEN-WLEN){w_raw[WLEN-1]}}, w_raw[WLEN-1:0]} : w_raw;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    // NOTE: each signal driven here gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        req_ready = !flush;
        w_accept  = req_valid && !flush;
        if (w_accept) w_state_next = S_PREP;
      end
      S_PREP: begin
        if (w_special) begin
          w_state_next = S_DONE;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (!w_is_div && (w_bmag == '0)) begin
          w_state_next = S_FIX;
`endif
        end else begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_next = S_FIX;
`ifdef MULDIV_EARLY_OUT_EN
        end else if (!w_is_div && ((r_mplier >> 1) == '0)) begin
          w_state_next = S_FIX;
`endif
        end
      end
      S_FIX: w_state_next = S_DONE;
      S_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // A flush kills whatever is in flight, including a pending response.
    if (flush) w_state_next = S_IDLE;
  end

  assign resp_result = r_result;

  // Request capture, operand preparation, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3 <= '0;
      r_word   <= 1'b0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_dsor   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        // Word forms of MULH/MULHSU/MULHU collapse onto MULW.
        r_funct3 <= (req_word && !req_funct3[2]) ? 3'b000 : req_funct3;
        r_word   <= req_word;
        r_opa    <= req_rs1;
        r_opb    <= req_rs2;
      end
      case (r_state)
        S_PREP: begin
          r_mcand  <= {{XLEN{1'b0}}, w_amag};
          r_acc    <= '0;
          r_mplier <= w_bmag;
          r_dsor   <= w_bmag;
          r_rem    <= '0;
          // Word dividends are left-aligned so the quotient lands in the low bits.
          r_quo    <= r_word ? {w_amag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : w_amag;
          r_cnt    <= r_word ? CNT_W'(WLEN - 1) : CNT_W'(XLEN - 1);
          r_neg    <= w_is_rem ? w_sa : (w_sa ^ w_sb);
          if (w_special) r_result <= w_special_res;
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_is_div) begin
            r_rem <= w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], w_qbit};
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        S_FIX: r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule
